// File: rtl/display_pkg.sv
// Shared display-datapath definitions: mode encodings, selector states and
// board default sizes.
package display_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        ST_MANUAL,
        ST_SCAN,
        ST_IDLE
    } state_t;

    localparam int DEF_NUM_CH = 8;
    localparam int DEF_DATA_W = 4;

endpackage

// File: rtl/channel_scan_mux_next_enabled_ch.sv
// Rotate-priority search: first enabled channel after ch, wrapping modulo
// NUM_CH and ending at ch itself, so a lone enabled ch maps to itself.
module next_enabled_ch #(
    parameter int NUM_CH = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [SEL_W-1:0]  ch,
    input  logic [NUM_CH-1:0] mask,
    output logic [SEL_W-1:0]  next_ch,
    output logic              any_en
);

    logic found;

    always_comb begin
        next_ch = ch;
        found   = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            int idx;
            idx = (int'(ch) + i) % NUM_CH;
            if (!found && mask[idx]) begin
                next_ch = SEL_W'(idx);
                found   = 1'b1;
            end
        end
        any_en = |mask;
    end

endmodule

// File: rtl/channel_scan_mux.sv
// Registered N-channel display selector with manual/scan modes and a
// post-change blanking window to suppress segment ghosting.
module channel_scan_mux
    import display_pkg::*;
#(
    parameter  int NUM_CH    = DEF_NUM_CH,
    parameter  int DATA_W    = DEF_DATA_W,
    parameter  int BLANK_CYC = 16,
    localparam int SEL_W     = $clog2(NUM_CH)
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NUM_CH*DATA_W-1:0] i_data,
    input  logic                     i_mode,
    input  logic [SEL_W-1:0]         i_sel,
    input  logic                     i_tick,
    input  logic [NUM_CH-1:0]        i_en_mask,
    output logic [DATA_W-1:0]        o_y,
    output logic [SEL_W-1:0]         o_ch,
    output logic                     o_valid,
    output logic                     o_blank
);

    // Counter keeps at least one bit so BLANK_CYC=0 still elaborates.
    localparam int CNT_W = (BLANK_CYC > 0) ? $clog2(BLANK_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] BLANK_LD = CNT_W'(BLANK_CYC);

    logic [NUM_CH-1:0][DATA_W-1:0] data_v;
    state_t                        st_q, st_d;
    logic [SEL_W-1:0]              ch_q, ch_d, nxt_ch;
    logic                          any_en, valid_d;
    logic [DATA_W-1:0]             y_d;
    logic [CNT_W-1:0]              blank_cnt;

    assign data_v = i_data;

    next_enabled_ch #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_search (
        .ch      (ch_q),
        .mask    (i_en_mask),
        .next_ch (nxt_ch),
        .any_en  (any_en)
    );

    always_comb begin
        st_d = ST_MANUAL;
        if (i_mode == MODE_SCAN)
            st_d = any_en ? ST_SCAN : ST_IDLE;
    end

    // Tick only advances once already scanning; a disabled ch always moves.
    always_comb begin
        ch_d    = ch_q;
        valid_d = 1'b0;
        case (st_d)
            ST_MANUAL: begin
                if (int'(i_sel) < NUM_CH) begin
                    ch_d    = i_sel;
                    valid_d = 1'b1;
                end
            end
            ST_SCAN: begin
                valid_d = 1'b1;
                if (!i_en_mask[ch_q] || (i_tick && st_q == ST_SCAN))
                    ch_d = nxt_ch;
            end
            default: ;
        endcase
        y_d = valid_d ? data_v[ch_d] : '0;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            st_q      <= ST_MANUAL;
            ch_q      <= '0;
            o_y       <= '0;
            o_valid   <= 1'b0;
            blank_cnt <= '0;
        end else begin
            st_q    <= st_d;
            ch_q    <= ch_d;
            o_y     <= y_d;
            o_valid <= valid_d;
            if (ch_d != ch_q)
                blank_cnt <= BLANK_LD;
            else if (blank_cnt != '0)
                blank_cnt <= blank_cnt - CNT_W'(1);
        end
    end

    assign o_ch    = ch_q;
    assign o_blank = (blank_cnt != '0);

endmodule

// File: tb/tb_channel_scan_mux.sv
// Directed bench for channel_scan_mux: NUM_CH=6, DATA_W=4, BLANK_CYC=3,
// channel k carries value k+1.
module tb_channel_scan_mux;

    localparam int NUM_CH    = 6;
    localparam int DATA_W    = 4;
    localparam int BLANK_CYC = 3;
    localparam int SEL_W     = $clog2(NUM_CH);

    logic                     i_clk = 1'b0;
    logic                     i_reset;
    logic [NUM_CH*DATA_W-1:0] i_data;
    logic                     i_mode;
    logic [SEL_W-1:0]         i_sel;
    logic                     i_tick;
    logic [NUM_CH-1:0]        i_en_mask;
    logic [DATA_W-1:0]        o_y;
    logic [SEL_W-1:0]         o_ch;
    logic                     o_valid;
    logic                     o_blank;

    int checks = 0;
    int passed = 0;

    channel_scan_mux #(
        .NUM_CH    (NUM_CH),
        .DATA_W    (DATA_W),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_data    (i_data),
        .i_mode    (i_mode),
        .i_sel     (i_sel),
        .i_tick    (i_tick),
        .i_en_mask (i_en_mask),
        .o_y       (o_y),
        .o_ch      (o_ch),
        .o_valid   (o_valid),
        .o_blank   (o_blank)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clk1();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int y, input int ch, input int v, input int b);
        chk({tag, ".y"},     32'(o_y),     32'(y));
        chk({tag, ".ch"},    32'(o_ch),    32'(ch));
        chk({tag, ".valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".blank"}, 32'(o_blank), 32'(b));
    endtask

    initial begin
        i_data    = 24'h654321;
        i_reset   = 1'b1;
        i_mode    = 1'b0;
        i_sel     = '0;
        i_tick    = 1'b0;
        i_en_mask = '0;
        clk1();
        clk1();
        chk_out("reset", 0, 0, 0, 0);
        i_reset = 1'b0;

        // manual select 0, then 0->4 with a 3-cycle blank
        clk1();
        chk_out("man0", 1, 0, 1, 0);
        i_sel = 3'd4;
        clk1();
        chk_out("man4", 5, 4, 1, 1);
        clk1();
        chk("blank_c2", 32'(o_blank), 32'd1);
        clk1();
        chk("blank_c3", 32'(o_blank), 32'd1);
        clk1();
        chk_out("blank_end", 5, 4, 1, 0);

        // illegal select holds ch, no blank
        i_sel = 3'd7;
        clk1();
        chk_out("illegal", 0, 4, 0, 0);

        // back to 0, let blank expire
        i_sel = 3'd0;
        clk1();
        chk_out("man0b", 1, 0, 1, 1);
        repeat (3) clk1();
        chk("blank_exp", 32'(o_blank), 32'd0);

        // scan entry on enabled ch 0: hold
        i_mode    = 1'b1;
        i_en_mask = 6'b100101;
        clk1();
        chk_out("scan_entry", 1, 0, 1, 0);

        // held tick: advance every cycle, wraps modulo 6
        i_tick = 1'b1;
        clk1(); chk("scan1", 32'(o_ch), 32'd2); chk("scan1.y", 32'(o_y), 32'd3);
        clk1(); chk("scan2", 32'(o_ch), 32'd5); chk("scan2.y", 32'(o_y), 32'd6);
        clk1(); chk("scan3", 32'(o_ch), 32'd0); chk("scan3.y", 32'(o_y), 32'd1);
        clk1(); chk("scan4", 32'(o_ch), 32'd2);
        clk1(); chk("scan5", 32'(o_ch), 32'd5);
        clk1(); chk("scan6", 32'(o_ch), 32'd0);
        clk1(); chk("scan7", 32'(o_ch), 32'd2);

        // mask drops ch 2 with no tick -> jump to 5
        i_tick    = 1'b0;
        i_en_mask = 6'b100001;
        clk1();
        chk_out("mask_jump", 6, 5, 1, 1);

        // empty mask -> idle
        i_en_mask = 6'b000000;
        clk1();
        chk_out("idle", 0, 5, 0, 1);
        i_en_mask = 6'b000010;
        clk1();
        chk_out("idle_exit", 2, 1, 1, 1);

        // manual 3, then scan entry with tick high: no advance
        i_mode = 1'b0;
        i_sel  = 3'd3;
        clk1();
        chk("man3.ch", 32'(o_ch), 32'd3);
        i_mode    = 1'b1;
        i_en_mask = 6'b001001;
        i_tick    = 1'b1;
        clk1();
        chk("entry_tick.ch", 32'(o_ch), 32'd3);
        clk1();
        chk("entry_adv.ch", 32'(o_ch), 32'd0);
        chk("entry_adv.y", 32'(o_y), 32'd1);

        // scan -> manual takes effect immediately
        i_mode = 1'b0;
        i_sel  = 3'd2;
        clk1();
        chk_out("to_manual", 3, 2, 1, 1);

        // reset mid-blank with a held tick
        i_mode    = 1'b1;
        i_en_mask = 6'b111111;
        i_tick    = 1'b1;
        i_reset   = 1'b1;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        clk1();
        chk_out("rst_hold", 0, 0, 0, 0);
        i_reset = 1'b0;
        i_mode  = 1'b0;
        i_tick  = 1'b0;
        i_sel   = 3'd3;
        clk1();
        chk_out("post_rst", 4, 3, 1, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/channel_scan_mux.md
# channel_scan_mux

Registered, parametrised N-channel selector that drives the 7-segment / display datapath of the fan-control board. It operates in one of two modes. In manual mode the channel comes from a select input. In scan mode it steps through a mask of enabled channels, one step per tick strobe. Each channel change is followed by a programmable blanking window that suppresses segment ghosting. It sits between the per-digit value generators and the display driver, and replaces the purely combinational digit selector.

## Interface
Parameters:
- NUM_CH, 8, number of input channels (≥2, need not be a power of 2)
- DATA_W, 4, width of each channel value
- BLANK_CYC, 16, clock cycles of o_blank after a channel change (0 = never blank)
- SEL_W, $clog2(NUM_CH), select/pointer width (derived, not overridden)

Ports (clock and reset first):
- i_clk  in  1  system clock, single clock domain
- i_reset  in  1  asynchronous, active-high reset
- i_data  in  NUM_CH*DATA_W  flattened channel values; channel k occupies bits [k*DATA_W +: DATA_W]
- i_mode  in  1  0 = MANUAL, 1 = SCAN
- i_sel  in  SEL_W  manual channel select
- i_tick  in  1  single-cycle scan advance strobe
- i_en_mask  in  NUM_CH  scan enable per channel
- o_y  out  DATA_W  selected value, registered
- o_ch  out  SEL_W  channel currently driven on o_y
- o_valid  out  1  o_y holds a legal channel's value
- o_blank  out  1  high during the blanking window

## Operation
- States:
  - MANUAL (i_mode=0).
  - SCAN (i_mode=1, mask non-zero).
  - IDLE (i_mode=1, mask all zero).
- State is re-evaluated every cycle from i_mode and i_en_mask.
- MANUAL:
  - ch_next = i_sel.
  - If i_sel ≥ NUM_CH: o_valid=0, o_y=0, o_ch holds its previous value.
- SCAN, on i_tick:
  - ch_next = first enabled channel after ch, searching ch+1 … NUM_CH-1, then 0 … ch (wrap).
  - If ch is the only enabled channel, ch_next = ch.
- SCAN, no tick:
  - If ch is enabled, hold.
  - If ch is disabled (mask changed, or entry from MANUAL onto a disabled channel), jump to the next enabled channel without waiting for a tick.
- IDLE: o_valid=0, o_y=0, ch holds.
- Mode change:
  - MANUAL→SCAN: the scan continues from the current ch. No advance in the entry cycle, even if i_tick=1.
  - SCAN→MANUAL: i_sel takes effect immediately.
- Blanking:
  - When the registered ch changes value, the blank counter loads BLANK_CYC. o_blank = (counter ≠ 0).
  - A further change during the window reloads the counter.
  - o_y still updates while blanking; the display driver gates on o_blank.
- o_y is always DATA_W bits, taken from slice ch_next of i_data. No arithmetic beyond the pointer wrap, which is modulo NUM_CH (not 2^SEL_W).

## Timing
- Reset (async assert, sync release): ch=0, o_ch=0, o_y=0, o_valid=0, o_blank=0, counter=0, state MANUAL.
- Latency: a change on i_sel, i_tick or i_data appears on o_y/o_ch/o_valid one clock edge later.
- o_blank rises on the same edge that o_ch changes. It stays high for exactly BLANK_CYC cycles, then falls.
- i_tick is sampled every cycle and is not required to be a single pulse. A tick held high advances once per cycle.
- Reset mid-blank or mid-scan clears everything to the reset values. The first post-reset edge follows the normal rules.
- Tick in the same cycle as a mask change: the search uses the new mask.

## Structure
- Shared package `display_pkg`:
  - mode constants MODE_MANUAL / MODE_SCAN
  - state enum {ST_MANUAL, ST_SCAN, ST_IDLE}
  - default DATA_W / NUM_CH for the board
- Sub-module `next_enabled_ch`: combinational rotate-priority search. Parameters NUM_CH/SEL_W. Inputs are the current ch and the mask. Outputs are next_ch and any_en.
- Top level holds the ch register, the output registers and the blank counter of width $clog2(BLANK_CYC+1).

## Test plan
All scenarios use NUM_CH=6, DATA_W=4, BLANK_CYC=3, with i_data channel k = k+1.
- MANUAL, i_sel 0→4 → one cycle later o_y=5, o_ch=4, o_valid=1, then o_blank high for exactly 3 cycles.
- MANUAL, i_sel=7 (illegal) → o_valid=0, o_y=0, o_ch held.
- SCAN, mask=6'b100101, start ch=0, five ticks → o_ch sequence 2, 5, 0, 2, 5 (wrap verified).
- SCAN on ch=2, then mask changes to 6'b100001 with no tick → next cycle o_ch=5.
- SCAN, mask=0 → o_valid=0, o_y=0; restoring mask=6'b000010 → o_ch=1, o_valid=1.
- Assert i_reset during a blank window and a held tick → all outputs 0 immediately. After release, MANUAL with i_sel=3 → o_y=4 one cycle later.
